// File: rtl/game_entry_loader.sv
`default_nettype none
// ============================================================================
// Module   : game_entry_loader
// Purpose  : Front-end for the Zood/Znarly grader. Collects the 4-shape master
//            pattern and each 4-shape guess one slot at a time. It presents
//            master0..3, Guess, GradeIt and ready to the grader, then waits
//            for the grader's round to finish before it accepts another guess.
// Ports    : CLOCK_50     - system clock, all state on posedge
//            reset        - asynchronous active-low reset
//            ShapeIn      - shape code for the selected slot
//            ShapeLoc     - slot index 0..3 (slot 0 = Guess[2:0])
//            LoadShape    - rising edge writes ShapeIn into slot ShapeLoc
//            StartGame    - rising edge commits master pattern / restarts
//            SubmitGuess  - rising edge submits the guess for grading
//            RoundNumber  - grader round counter
//            GameOver     - grader game-over flag
//            master0..3   - committed master pattern
//            Guess        - assembled guess {slot3,slot2,slot1,slot0}
//            GradeIt      - one-cycle grade request
//            ready        - master valid and a game is in progress
//            SlotsFilled  - bit i set = slot i written since last clear
//            ShapeError   - sticky flag for a rejected action
//            GradeTimeout - sticky flag for a grader round that never finished
// Revision : 1.0 - initial release
// ============================================================================
module game_entry_loader #(
   parameter int NUM_SHAPES    = 6,
   parameter int GRADE_TIMEOUT = 64
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [2:0]  ShapeIn,
   input  logic [1:0]  ShapeLoc,
   input  logic        LoadShape,
   input  logic        StartGame,
   input  logic        SubmitGuess,
   input  logic [3:0]  RoundNumber,
   input  logic        GameOver,
   output logic [2:0]  master0,
   output logic [2:0]  master1,
   output logic [2:0]  master2,
   output logic [2:0]  master3,
   output logic [11:0] Guess,
   output logic        GradeIt,
   output logic        ready,
   output logic [3:0]  SlotsFilled,
   output logic        ShapeError,
   output logic        GradeTimeout
);

   localparam int               CNT_W      = $clog2(GRADE_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(GRADE_TIMEOUT - 1);
   localparam logic [3:0]       C_NUM      = 4'(NUM_SHAPES);

   typedef enum logic [2:0] {
      LOAD_MASTER = 3'd0,
      ENTER_GUESS = 3'd1,
      GRADE       = 3'd2,
      WAIT_GRADE  = 3'd3,
      GAME_END    = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Input capture (cur) and one-cycle history (prev) for edge detection
   logic r_load_cur, r_load_prev;
   logic r_start_cur, r_start_prev;
   logic r_submit_cur, r_submit_prev;

   logic [2:0]       r_mbuf   [4];   // master pattern being entered
   logic [2:0]       r_master [4];   // committed master pattern
   logic [2:0]       r_gbuf   [4];   // guess slots, drive Guess directly
   logic [3:0]       r_filled;
   logic             r_grade_it;
   logic             r_shape_err;
   logic             r_grade_to;
   logic [3:0]       r_rn;
   logic [CNT_W-1:0] r_cnt;

   logic w_load_edge, w_start_edge, w_submit_edge;
   logic w_code_ok, w_full;
   logic w_slot_wr, w_commit, w_submit, w_restart;
   logic w_round_done, w_timeout, w_err_set, w_err_clr;

   assign w_load_edge   = r_load_cur   & ~r_load_prev;
   assign w_start_edge  = r_start_cur  & ~r_start_prev;
   assign w_submit_edge = r_submit_cur & ~r_submit_prev;
   assign w_code_ok     = ({1'b0, ShapeIn} < C_NUM);
   assign w_full        = (r_filled == 4'hF);

   // State register
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) r_state <= LOAD_MASTER;
      else        r_state <= w_state_next;
   end

   // Next state and action strobes. In the entry states a load edge takes
   // priority over any other edge arriving in the same cycle.
   always_comb begin
      w_state_next = r_state;
      w_slot_wr    = 1'b0;
      w_commit     = 1'b0;
      w_submit     = 1'b0;
      w_restart    = 1'b0;
      w_round_done = 1'b0;
      w_timeout    = 1'b0;
      w_err_set    = 1'b0;
      w_err_clr    = 1'b0;
      case (r_state)
         LOAD_MASTER: begin
            if (w_load_edge) begin
               if (w_code_ok) begin
                  w_slot_wr = 1'b1;
                  w_err_clr = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
            end else if (w_start_edge) begin
               if (w_full) begin
                  w_commit     = 1'b1;
                  w_err_clr    = 1'b1;
                  w_state_next = ENTER_GUESS;
               end else begin
                  w_err_set = 1'b1;
               end
            end
         end
         ENTER_GUESS: begin
            if (w_load_edge) begin
               if (w_code_ok) begin
                  w_slot_wr = 1'b1;
                  w_err_clr = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
            end else if (w_submit_edge) begin
               if (w_full) begin
                  w_submit     = 1'b1;
                  w_err_clr    = 1'b1;
                  w_state_next = GRADE;
               end else begin
                  w_err_set = 1'b1;
               end
            end
         end
         GRADE: begin
            w_state_next = WAIT_GRADE;
         end
         WAIT_GRADE: begin
            if (GameOver) begin
               w_state_next = GAME_END;
            end else if (RoundNumber != r_rn) begin
               w_round_done = 1'b1;
               w_state_next = ENTER_GUESS;
            end else if (r_cnt >= C_CNT_LAST) begin
               w_timeout    = 1'b1;
               w_state_next = ENTER_GUESS;
            end
         end
         GAME_END: begin
            if (w_start_edge) begin
               w_restart    = 1'b1;
               w_err_clr    = 1'b1;
               w_state_next = LOAD_MASTER;
            end
         end
         default: w_state_next = LOAD_MASTER;
      endcase
   end

   // Datapath
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_load_cur    <= 1'b0;
         r_load_prev   <= 1'b0;
         r_start_cur   <= 1'b0;
         r_start_prev  <= 1'b0;
         r_submit_cur  <= 1'b0;
         r_submit_prev <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_mbuf[i]   <= '0;
            r_master[i] <= '0;
            r_gbuf[i]   <= '0;
         end
         r_filled    <= '0;
         r_grade_it  <= 1'b0;
         r_shape_err <= 1'b0;
         r_grade_to  <= 1'b0;
         r_rn        <= '0;
         r_cnt       <= '0;
      end else begin
         r_load_cur    <= LoadShape;
         r_load_prev   <= r_load_cur;
         r_start_cur   <= StartGame;
         r_start_prev  <= r_start_cur;
         r_submit_cur  <= SubmitGuess;
         r_submit_prev <= r_submit_cur;

         r_grade_it <= w_submit;

         if (w_slot_wr) begin
            if (r_state == LOAD_MASTER) r_mbuf[ShapeLoc] <= ShapeIn;
            else                        r_gbuf[ShapeLoc] <= ShapeIn;
            r_filled[ShapeLoc] <= 1'b1;
         end

         if (w_commit) begin
            for (int i = 0; i < 4; i++) r_master[i] <= r_mbuf[i];
            r_filled   <= '0;
            r_grade_to <= 1'b0;
         end

         if (w_submit) r_rn <= RoundNumber;

         // Counter restarts in GRADE so WAIT_GRADE always begins at zero;
         // it holds at the last value rather than wrapping.
         if (r_state == GRADE) begin
            r_cnt <= '0;
         end else if (r_state == WAIT_GRADE && r_cnt != C_CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_round_done) begin
            r_filled <= '0;
            for (int i = 0; i < 4; i++) r_gbuf[i] <= '0;
         end

         // Guess and SlotsFilled are kept so the same guess can be resubmitted
         if (w_timeout) r_grade_to <= 1'b1;

         if (w_restart) begin
            for (int i = 0; i < 4; i++) begin
               r_master[i] <= '0;
               r_gbuf[i]   <= '0;
               r_mbuf[i]   <= '0;
            end
            r_filled   <= '0;
            r_grade_to <= 1'b0;
         end

         if (w_err_set)      r_shape_err <= 1'b1;
         else if (w_err_clr) r_shape_err <= 1'b0;
      end
   end

   assign master0      = r_master[0];
   assign master1      = r_master[1];
   assign master2      = r_master[2];
   assign master3      = r_master[3];
   assign Guess        = {r_gbuf[3], r_gbuf[2], r_gbuf[1], r_gbuf[0]};
   assign GradeIt      = r_grade_it;
   assign SlotsFilled  = r_filled;
   assign ShapeError   = r_shape_err;
   assign GradeTimeout = r_grade_to;
   assign ready        = (r_state == ENTER_GUESS) || (r_state == GRADE) ||
                         (r_state == WAIT_GRADE)  || (r_state == GAME_END);

endmodule
`default_nettype wire

// File: tb/tb_game_entry_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_entry_loader
// Purpose  : Self-checking bench for game_entry_loader using a table of slot
//            writes plus directed sequences for the multi-cycle behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_entry_loader;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b0;
   logic [2:0]  ShapeIn  = '0;
   logic [1:0]  ShapeLoc = '0;
   logic        LoadShape = 1'b0, StartGame = 1'b0, SubmitGuess = 1'b0;
   logic [3:0]  RoundNumber = '0;
   logic        GameOver = 1'b0;
   logic [2:0]  master0, master1, master2, master3;
   logic [11:0] Guess;
   logic        GradeIt, ready, ShapeError, GradeTimeout;
   logic [3:0]  SlotsFilled;

   int n_checks = 0;
   int n_pass   = 0;

   game_entry_loader #(.NUM_SHAPES(6), .GRADE_TIMEOUT(64)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .ShapeIn(ShapeIn), .ShapeLoc(ShapeLoc),
      .LoadShape(LoadShape), .StartGame(StartGame), .SubmitGuess(SubmitGuess),
      .RoundNumber(RoundNumber), .GameOver(GameOver),
      .master0(master0), .master1(master1), .master2(master2), .master3(master3),
      .Guess(Guess), .GradeIt(GradeIt), .ready(ready), .SlotsFilled(SlotsFilled),
      .ShapeError(ShapeError), .GradeTimeout(GradeTimeout)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [1:0]  loc;
      logic [2:0]  code;
      logic [3:0]  exp_filled;
      logic        exp_err;
      logic [11:0] exp_guess;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [11:0] masters();
      return {master3, master2, master1, master0};
   endfunction

   task automatic do_load(input logic [1:0] loc, input logic [2:0] code);
      ShapeLoc  = loc;
      ShapeIn   = code;
      LoadShape = 1'b1;
      tick();
      tick();
      LoadShape = 1'b0;
      tick();
   endtask

   task automatic do_start();
      StartGame = 1'b1;
      tick();
      tick();
      StartGame = 1'b0;
      tick();
   endtask

   // Submit with GradeIt timing checks; ends one cycle into WAIT_GRADE
   task automatic do_submit_checked(input string tag);
      SubmitGuess = 1'b1;
      tick();
      check({tag, "_gradeit_c1"}, GradeIt, 0);
      tick();
      check({tag, "_gradeit_c2"}, GradeIt, 1);
      SubmitGuess = 1'b0;
      tick();
      check({tag, "_gradeit_c3"}, GradeIt, 0);
   endtask

   initial begin
      // Guess entry table: {slot3..slot0} shown as octal
      vecs[0] = '{2'd0, 3'd2, 4'b0001, 1'b0, 12'o0002};
      vecs[1] = '{2'd1, 3'd3, 4'b0011, 1'b0, 12'o0032};
      vecs[2] = '{2'd2, 3'd6, 4'b0011, 1'b1, 12'o0032};
      vecs[3] = '{2'd2, 3'd4, 4'b0111, 1'b0, 12'o0432};
      vecs[4] = '{2'd3, 3'd5, 4'b1111, 1'b0, 12'o5432};
      vecs[5] = '{2'd0, 3'd7, 4'b1111, 1'b1, 12'o5432};
      vecs[6] = '{2'd1, 3'd0, 4'b1111, 1'b0, 12'o5402};
      vecs[7] = '{2'd1, 3'd3, 4'b1111, 1'b0, 12'o5432};

      // Reset state
      #1;
      check("rst_master", masters(), 0);
      check("rst_guess", Guess, 0);
      check("rst_ready", ready, 0);
      check("rst_filled", SlotsFilled, 0);
      check("rst_flags", {GradeIt, ShapeError, GradeTimeout}, 0);
      tick();
      reset = 1'b1;
      tick();

      // Master load and commit
      do_load(2'd0, 3'd1);
      do_load(2'd1, 3'd2);
      do_load(2'd2, 3'd3);
      do_load(2'd3, 3'd4);
      check("m_filled", SlotsFilled, 4'hF);
      check("m_ready_before", ready, 0);
      do_start();
      check("m_master", masters(), 12'o4321);
      check("m_ready", ready, 1);
      check("m_filled_clr", SlotsFilled, 0);

      // Table-driven guess entry
      for (int i = 0; i < 8; i++) begin
         do_load(vecs[i].loc, vecs[i].code);
         check($sformatf("tbl%0d_filled", i), SlotsFilled, vecs[i].exp_filled);
         check($sformatf("tbl%0d_err", i), ShapeError, vecs[i].exp_err);
         check($sformatf("tbl%0d_guess", i), Guess, vecs[i].exp_guess);
      end

      // Submit, frozen guess in WAIT_GRADE, round advance
      do_submit_checked("sub1");
      do_load(2'd0, 3'd1);
      check("wait_guess_frozen", Guess, 12'o5432);
      check("wait_filled", SlotsFilled, 4'hF);
      do_start();
      check("wait_start_ignored", masters(), 12'o4321);
      check("wait_ready", ready, 1);
      RoundNumber = 4'd1;
      tick();
      check("rnd_guess_clr", Guess, 0);
      check("rnd_filled_clr", SlotsFilled, 0);
      check("rnd_ready", ready, 1);
      check("rnd_gradeit", GradeIt, 0);

      // Bad code and incomplete submit
      do_load(2'd0, 3'd1);
      do_load(2'd1, 3'd1);
      do_load(2'd3, 3'd6);
      check("bad_err", ShapeError, 1);
      check("bad_filled", SlotsFilled, 4'b0011);
      do_load(2'd2, 3'd1);
      check("good_err_clr", ShapeError, 0);
      check("good_guess", Guess, 12'o0111);
      SubmitGuess = 1'b1;
      tick();
      check("inc_gradeit_c1", GradeIt, 0);
      tick();
      check("inc_gradeit_c2", GradeIt, 0);
      SubmitGuess = 1'b0;
      tick();
      check("inc_gradeit_c3", GradeIt, 0);
      check("inc_err", ShapeError, 1);
      do_load(2'd3, 3'd1);
      check("full_guess", Guess, 12'o1111);
      check("full_err", ShapeError, 0);

      // Level held high: exactly one write
      ShapeLoc = 2'd0; ShapeIn = 3'd3; LoadShape = 1'b1;
      tick();
      tick();
      check("hold_first", Guess, 12'o1113);
      ShapeIn = 3'd4;
      tick();
      tick();
      check("hold_once", Guess, 12'o1113);
      LoadShape = 1'b0;
      tick();

      // Same-cycle load and submit: only the load happens
      ShapeLoc = 2'd1; ShapeIn = 3'd5;
      LoadShape = 1'b1; SubmitGuess = 1'b1;
      tick();
      tick();
      check("both_guess", Guess, 12'o1153);
      check("both_gradeit", GradeIt, 0);
      LoadShape = 1'b0; SubmitGuess = 1'b0;
      tick();
      check("both_gradeit2", GradeIt, 0);

      // Timeout: WAIT_GRADE lasts 64 cycles with RoundNumber unchanged
      do_submit_checked("sub2");
      repeat (63) tick();
      check("to_not_yet", GradeTimeout, 0);
      tick();
      check("to_set", GradeTimeout, 1);
      check("to_guess_kept", Guess, 12'o1153);
      check("to_filled_kept", SlotsFilled, 4'hF);
      check("to_ready", ready, 1);

      // Resubmit, then GameOver
      do_submit_checked("sub3");
      GameOver = 1'b1;
      tick();
      GameOver = 1'b0;
      check("end_ready", ready, 1);
      check("end_master", masters(), 12'o4321);
      SubmitGuess = 1'b1;
      tick();
      tick();
      check("end_submit_ignored", GradeIt, 0);
      SubmitGuess = 1'b0;
      tick();
      do_load(2'd0, 3'd0);
      check("end_load_ignored", Guess, 12'o1153);
      do_start();
      check("restart_ready", ready, 0);
      check("restart_master", masters(), 0);
      check("restart_guess", Guess, 0);
      check("restart_filled", SlotsFilled, 0);
      check("restart_timeout", GradeTimeout, 0);

      // Asynchronous reset while in WAIT_GRADE
      do_load(2'd0, 3'd5);
      do_load(2'd1, 3'd4);
      do_load(2'd2, 3'd3);
      do_load(2'd3, 3'd2);
      do_start();
      check("m2_master", masters(), 12'o2345);
      do_load(2'd0, 3'd1);
      do_load(2'd1, 3'd1);
      do_load(2'd2, 3'd1);
      do_load(2'd3, 3'd1);
      do_submit_checked("sub4");
      #2;
      reset = 1'b0;
      #1;
      check("arst_master", masters(), 0);
      check("arst_guess", Guess, 0);
      check("arst_ready", ready, 0);
      check("arst_filled", SlotsFilled, 0);
      check("arst_flags", {GradeIt, ShapeError, GradeTimeout}, 0);
      reset = 1'b1;
      tick();
      // Back in LOAD_MASTER: StartGame with no slots filled is rejected
      do_start();
      check("post_rst_err", ShapeError, 1);
      check("post_rst_ready", ready, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
